uart_avalon_regs: RTL and testbench

Avalon-MM slave register front-end for the UART core, sitting directly upstream of the core's TX path and downstream of its RX path. It buffers CPU-written bytes in a TX FIFO and feeds them to the core over a valid/ready handshake. Received bytes from the core are captured into an RX FIFO for CPU readout. It also provides status, interrupt control and a baud divisor register.

---
 rtl/uart_avalon_regs_if.sv | 25 ++
 rtl/uart_avalon_regs.sv | 174 +++++++++++++++++
 tb/tb_uart_avalon_regs.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_avalon_regs_if.sv
// Avalon-MM slave bus bundle for the UART register front-end.
// The master modport is the CPU side; the slave modport is the register block.
interface uart_avalon_regs_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/uart_avalon_regs.sv
// UART register front-end: TX/RX byte FIFOs, status with sticky overflow flags,
// interrupt control and baud divisor, exposed as an Avalon-MM slave.
module uart_avalon_regs #(
    parameter int          FIFO_AW      = 4,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_avalon_regs_if.slave   avs,
    output logic                irq,
    output logic                core_tx_valid,
    input  logic                core_tx_ready,
    output logic [7:0]          core_tx_data,
    input  logic                core_rx_strobe,
    input  logic [7:0]          core_rx_data,
    output logic [15:0]         baud_div
);
    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_BAUD    = 2'd3;

    logic [7:0]         r_tx_mem [0:DEPTH-1];
    logic [7:0]         r_rx_mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [FIFO_AW-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [FIFO_AW:0]   r_tx_count, r_rx_count;
    logic [1:0]         r_sticky;
    logic [1:0]         r_ctrl;
    logic [15:0]        r_baud;
    logic [31:0]        r_readdata;
    logic               r_irq;

    logic        w_wr_data, w_wr_status, w_wr_control, w_wr_baud;
    logic        w_rd, w_rd_data;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_pop, w_tx_push, w_rx_pop, w_rx_push;
    logic [1:0]  w_sticky_set, w_sticky_clr;
    logic [31:0] w_rd_value;
    logic [7:0]  w_tx_count8, w_rx_count8;
    logic        w_unused;

    assign w_unused = &{1'b0, avs.avs_writedata[31:16]};

    // A write wins over a simultaneous read; such a read neither pops nor returns data.
    assign w_rd         = avs.avs_read && !avs.avs_write;
    assign w_rd_data    = w_rd && (avs.avs_address == ADDR_DATA);
    assign w_wr_data    = avs.avs_write && (avs.avs_address == ADDR_DATA);
    assign w_wr_status  = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    assign w_wr_control = avs.avs_write && (avs.avs_address == ADDR_CONTROL);
    assign w_wr_baud    = avs.avs_write && (avs.avs_address == ADDR_BAUD);

    assign w_tx_full  = (r_tx_count == FULL_CNT);
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == FULL_CNT);
    assign w_rx_empty = (r_rx_count == '0);

    // A push into a full FIFO is only taken when the same cycle frees a slot.
    assign w_tx_pop  = !w_tx_empty && core_tx_ready;
    assign w_tx_push = w_wr_data && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = w_rd_data && !w_rx_empty;
    assign w_rx_push = core_rx_strobe && (!w_rx_full || w_rx_pop);

    // Sticky bit 0 is RX_OVR (STATUS bit 4), bit 1 is TX_OVF (STATUS bit 5).
    assign w_sticky_set[0] = core_rx_strobe && w_rx_full && !w_rx_pop;
    assign w_sticky_set[1] = w_wr_data && w_tx_full && !w_tx_pop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sticky
            assign w_sticky_clr[gi] = w_wr_status && avs.avs_writedata[4+gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sticky[gi] <= 1'b0;
                end else if (w_sticky_set[gi]) begin
                    r_sticky[gi] <= 1'b1;
                end else if (w_sticky_clr[gi]) begin
                    r_sticky[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= avs.avs_writedata[7:0];
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= core_rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
            end
            r_tx_count <= r_tx_count + (w_tx_push ? CNT_ONE : '0) - (w_tx_pop ? CNT_ONE : '0);
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            end
            r_rx_count <= r_rx_count + (w_rx_push ? CNT_ONE : '0) - (w_rx_pop ? CNT_ONE : '0);
        end
    end

    assign w_tx_count8 = 8'(r_tx_count);
    assign w_rx_count8 = 8'(r_rx_count);

    always_comb begin
        w_rd_value = '0;
        case (avs.avs_address)
            ADDR_DATA: begin
                if (!w_rx_empty) begin
                    w_rd_value = {16'h0000, 1'b1, 7'b0, r_rx_mem[r_rx_rd_ptr]};
                end
            end
            ADDR_STATUS: begin
                w_rd_value = {8'h00, w_tx_count8, w_rx_count8, 2'b00, r_sticky[1], r_sticky[0],
                              w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
            end
            ADDR_CONTROL: begin
                w_rd_value = {30'b0, r_ctrl};
            end
            default: begin
                w_rd_value = {16'h0000, r_baud};
            end
        endcase
    end

    // Readdata and irq sample pre-update state, so both lag the bus/FIFO by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_ctrl     <= 2'b00;
            r_baud     <= BAUD_DIV_RST;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rd ? w_rd_value : '0;
            if (w_wr_control) begin
                r_ctrl <= avs.avs_writedata[1:0];
            end
            if (w_wr_baud) begin
                r_baud <= (avs.avs_writedata[15:0] == 16'h0000) ? 16'h0001 : avs.avs_writedata[15:0];
            end
            r_irq <= (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_empty) || r_sticky[0];
        end
    end

    assign avs.avs_readdata = r_readdata;
    assign irq              = r_irq;
    assign baud_div         = r_baud;
    assign core_tx_valid    = !w_tx_empty;
    assign core_tx_data     = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr];

endmodule

// File: tb/tb_uart_avalon_regs.sv
// Directed bench for the UART register front-end: FIFO ordering, overflow,
// full-FIFO simultaneous push/pop, interrupt timing, baud divisor and reset.
module tb_uart_avalon_regs;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq;
    logic        core_tx_valid;
    logic        core_tx_ready = 1'b0;
    logic [7:0]  core_tx_data;
    logic        core_rx_strobe = 1'b0;
    logic [7:0]  core_rx_data = 8'h00;
    logic [15:0] baud_div;

    int checks = 0;
    int errors = 0;

    uart_avalon_regs_if avs ();

    uart_avalon_regs #(
        .FIFO_AW      (4),
        .BAUD_DIV_RST (16'd434)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs            (avs.slave),
        .irq            (irq),
        .core_tx_valid  (core_tx_valid),
        .core_tx_ready  (core_tx_ready),
        .core_tx_data   (core_tx_data),
        .core_rx_strobe (core_rx_strobe),
        .core_rx_data   (core_rx_data),
        .baud_div       (baud_div)
    );

    always #5 clk = ~clk;

    // Bus helpers start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs.avs_address   = addr;
        avs.avs_writedata = data;
        avs.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs.avs_write     = 1'b0;
        $display("wr addr=%0d data=%08h", addr, data);
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        avs.avs_address = addr;
        avs.avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs.avs_read    = 1'b0;
        data            = avs.avs_readdata;
        $display("rd addr=%0d data=%08h", addr, data);
    endtask

    task automatic rx_push(input logic [7:0] b);
        core_rx_data   = b;
        core_rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        core_rx_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++;
        if (core_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", core_tx_valid); end
        checks++;
        if (core_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", core_tx_data); end
        checks++;
        if (baud_div !== 16'd434) begin errors++; $display("FAIL reset_baud_div got %0d want 434", baud_div); end
        checks++;
        if (avs.avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %08h want 0", avs.avs_readdata); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0006) begin errors++; $display("FAIL reset_status got %08h want 00000006", rd); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'd434) begin errors++; $display("FAIL reset_baud_reg got %08h want %08h", rd, 32'd434); end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_control got %08h want 0", rd); end
    endtask

    task automatic test_tx_order();
        logic [31:0] rd;
        logic [7:0]  exp_b [3] = '{8'h41, 8'h42, 8'h43};
        core_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, {24'h0, exp_b[i]});
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0003_0004) begin errors++; $display("FAIL tx3_status got %08h want 00030004", rd); end
        core_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (core_tx_valid !== 1'b1 || core_tx_data !== exp_b[i]) begin
                errors++;
                $display("FAIL tx_order[%0d] got v=%b d=%h want v=1 d=%h", i, core_tx_valid, core_tx_data, exp_b[i]);
            end
            @(posedge clk);
            #1;
        end
        core_tx_ready = 1'b0;
        checks++;
        if (core_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid got %b want 0", core_tx_valid); end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0006) begin errors++; $display("FAIL tx_drained_status got %08h want 00000006", rd); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd;
        logic [7:0]  exp_b;
        core_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0010_0025) begin errors++; $display("FAIL tx_ovf_status got %08h want 00100025", rd); end
        bus_write(2'd1, 32'h0000_0020);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0010_0005) begin errors++; $display("FAIL tx_ovf_clear got %08h want 00100005", rd); end
        // Full FIFO: a push coinciding with a pop is accepted without overflow.
        avs.avs_address   = 2'd0;
        avs.avs_writedata = 32'h0000_00EE;
        avs.avs_write     = 1'b1;
        core_tx_ready     = 1'b1;
        @(posedge clk);
        #1;
        avs.avs_write     = 1'b0;
        core_tx_ready     = 1'b0;
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0010_0005) begin errors++; $display("FAIL tx_full_pushpop_status got %08h want 00100005", rd); end
        core_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i == 15) ? 8'hEE : 8'(i + 1);
            checks++;
            if (core_tx_valid !== 1'b1 || core_tx_data !== exp_b) begin
                errors++;
                $display("FAIL tx_full_drain[%0d] got v=%b d=%h want v=1 d=%h", i, core_tx_valid, core_tx_data, exp_b);
            end
            @(posedge clk);
            #1;
        end
        core_tx_ready = 1'b0;
        checks++;
        if (core_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_full_drain_end got %b want 0", core_tx_valid); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] rd;
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_101A) begin errors++; $display("FAIL rx_ovr_status got %08h want 0000101a", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_ovr_irq got %b want 1", irq); end
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd);
            checks++;
            if (rd !== (32'h0000_8000 | 32'(i))) begin
                errors++;
                $display("FAIL rx_drain[%0d] got %08h want %08h", i, rd, 32'h0000_8000 | 32'(i));
            end
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_empty_read got %08h want 00000000", rd); end
        bus_write(2'd1, 32'h0000_0010);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0006) begin errors++; $display("FAIL rx_ovr_clear got %08h want 00000006", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_ovr_irq_clear got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  exp_b;
        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        avs.avs_address = 2'd0;
        avs.avs_read    = 1'b1;
        core_rx_data    = 8'h55;
        core_rx_strobe  = 1'b1;
        @(posedge clk);
        #1;
        avs.avs_read    = 1'b0;
        core_rx_strobe  = 1'b0;
        checks++;
        if (avs.avs_readdata !== 32'h0000_8060) begin
            errors++;
            $display("FAIL rx_full_pushpop_read got %08h want 00008060", avs.avs_readdata);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_100A) begin errors++; $display("FAIL rx_full_pushpop_status got %08h want 0000100a", rd); end
        for (int i = 0; i < 16; i++) begin
            exp_b = (i == 15) ? 8'h55 : 8'(8'h61 + i);
            bus_read(2'd0, rd);
            checks++;
            if (rd !== {16'h0, 8'h80, exp_b}) begin
                errors++;
                $display("FAIL rx_full_drain[%0d] got %08h want %08h", i, rd, {16'h0, 8'h80, exp_b});
            end
        end
    endtask

    task automatic test_irq_baud();
        logic [31:0] rd;
        bus_write(2'd2, 32'h0000_0001);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL control_read got %08h want 00000001", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        rx_push(8'hA5);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag1 got %b want 0", irq); end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx got %b want 1", irq); end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0000_80A5) begin errors++; $display("FAIL irq_rx_data got %08h want 000080a5", rd); end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop got %b want 0", irq); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL control_mask got %08h want 00000003", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got %b want 1", irq); end
        bus_write(2'd3, 32'h0000_0000);
        checks++;
        if (baud_div !== 16'd1) begin errors++; $display("FAIL baud_zero got %0d want 1", baud_div); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL baud_zero_read got %08h want 00000001", rd); end
        // Simultaneous read and write: write lands, read returns zero.
        avs.avs_address   = 2'd3;
        avs.avs_writedata = 32'hABCD_1234;
        avs.avs_write     = 1'b1;
        avs.avs_read      = 1'b1;
        @(posedge clk);
        #1;
        avs.avs_write     = 1'b0;
        avs.avs_read      = 1'b0;
        checks++;
        if (avs.avs_readdata !== 32'h0) begin errors++; $display("FAIL rw_collision_read got %08h want 0", avs.avs_readdata); end
        checks++;
        if (baud_div !== 16'h1234) begin errors++; $display("FAIL rw_collision_baud got %h want 1234", baud_div); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        bus_write(2'd0, 32'h0000_0077);
        checks++;
        if (core_tx_valid !== 1'b1 || core_tx_data !== 8'h77) begin
            errors++;
            $display("FAIL pre_reset_tx got v=%b d=%h want v=1 d=77", core_tx_valid, core_tx_data);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (core_tx_valid !== 1'b0 || baud_div !== 16'd434 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b baud=%0d irq=%b want v=0 baud=434 irq=0", core_tx_valid, baud_div, irq);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0006) begin errors++; $display("FAIL async_reset_status got %08h want 00000006", rd); end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL async_reset_control got %08h want 0", rd); end
    endtask

    initial begin
        avs.avs_address   = 2'd0;
        avs.avs_read      = 1'b0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = 32'h0;
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_rx_overflow();
        test_back_to_back();
        test_irq_baud();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
